// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: pixel/address widths, the {row,col}
// address packing used by both the input and output paths, and the
// output-writer state encoding.
package cnn_pkg;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 16;
    localparam int COORD_W = 8;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_WRITE = 2'd1,
        WR_FLUSH = 2'd2
    } wr_state_e;

    // MEM address = {row, col}, each field COORD_W bits wide.
    function automatic logic [ADDR_W-1:0] pack_addr(input logic [COORD_W-1:0] row,
                                                    input logic [COORD_W-1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/out_addr_cnt.sv
// Raster row/col counter for an OUT x OUT output map. Advances col on each
// beat, wraps col into row, wraps row back to 0 after the last pixel, and
// flags the last pixel of the frame.
module out_addr_cnt
    import cnn_pkg::*;
#(
    parameter int OUT = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               adv,
    output logic [COORD_W-1:0] row,
    output logic [COORD_W-1:0] col,
    output logic               last
);

    localparam logic [COORD_W-1:0] EDGE_MAX = COORD_W'(OUT - 1);

    logic [COORD_W-1:0] row_q, row_d;
    logic [COORD_W-1:0] col_q, col_d;

    // Next raster position: clear on frame start, step on accepted beat.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        row_d = row_q;
        col_d = col_q;
        if (clr) begin
            row_d = '0;
            col_d = '0;
        end else if (adv) begin
            if (col_q == EDGE_MAX) begin
                col_d = '0;
                row_d = (row_q == EDGE_MAX) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Position registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row  = row_q;
    assign col  = col_q;
    assign last = (row_q == EDGE_MAX) && (col_q == EDGE_MAX);

endmodule

// File: rtl/conv_out_writer.sv
// Output feature-map writer: accepts the conv result stream in raster order
// and writes each pixel to MEM at {row,col} one cycle after acceptance.
// Optional macro RELU_EN clamps negative pixels to zero on the write path.
module conv_out_writer
    import cnn_pkg::*;
#(
    parameter int SIZE = 14,
    parameter int K    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              busy,
    output logic              done
);

    localparam int OUT = SIZE - K + 1;

    // Row/col fields are 8 bits each, so the output edge cannot exceed 256.
    if (OUT > 256 || OUT < 1) begin : g_bad_out
        $error("conv_out_writer: OUT=%0d must be in 1..256", OUT);
    end

    wr_state_e          state_q, state_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_data_q, mem_data_d;
    logic [DATA_W-1:0]  wr_data;
    logic [COORD_W-1:0] row, col;
    logic               last;
    logic               accept;
    logic               cnt_clr;

    assign accept  = in_valid && (state_q == WR_WRITE);
    assign cnt_clr = (state_q == WR_IDLE) && start;

    out_addr_cnt #(.OUT(OUT)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .adv  (accept),
        .row  (row),
        .col  (col),
        .last (last)
    );

    // Write-path data: optional ReLU, purely combinational (no extra latency).
    always_comb begin
`ifdef RELU_EN
        wr_data = in_data[DATA_W-1] ? '0 : in_data;
`else
        wr_data = in_data;
`endif
    end

    // Frame sequencing and next values of the MEM-side output registers.
    always_comb begin
        state_d    = state_q;
        mem_we_d   = accept;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        if (accept) begin
            mem_addr_d = pack_addr(row, col);
            mem_data_d = wr_data;
        end
        case (state_q)
            WR_IDLE:  if (start) state_d = WR_WRITE;
            WR_WRITE: if (accept && last) state_d = WR_FLUSH;
            WR_FLUSH: state_d = WR_IDLE;
            default:  state_d = WR_IDLE;
        endcase
    end

    // State and output registers; reset abandons any partial frame.
    always_ff @(posedge clk) begin
        // NOTE: only control and output flops exist here, so all are reset; no storage array needs clearing.
        if (rst) begin
            state_q    <= WR_IDLE;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
        end
    end

    assign in_ready = (state_q == WR_WRITE);
    assign busy     = (state_q != WR_IDLE);
    assign done     = (state_q == WR_FLUSH);
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;

endmodule

// File: tb/tb_conv_out_writer.sv
// Self-checking bench for conv_out_writer (SIZE=14, K=3 -> 12x12 output,
// 144 beats per frame). A frame-level reference model predicts every
// output each cycle from beat counts and raster arithmetic.
module tb_conv_out_writer;

    localparam int OUT    = 12;
    localparam int BEATS  = OUT * OUT;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        busy;
    logic        done;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: frame phase (0 idle, 1 collecting beats, 2 final-write
    // cycle), beats accepted so far, and the expected MEM-side outputs.
    int          m_phase = 0;
    int          m_n     = 0;
    logic        m_we    = 1'b0;
    logic [15:0] m_addr  = '0;
    logic [15:0] m_data  = '0;
    int          done_seen = 0;

    conv_out_writer #(.SIZE(14), .K(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] relu(input logic [15:0] d);
`ifdef RELU_EN
        return ($signed(d) < 0) ? 16'h0000 : d;
`else
        return d;
`endif
    endfunction

    // Drive one cycle of inputs, advance the model, then compare all outputs
    // 1 time unit after the clock edge.
    task automatic step(input logic r, input logic st, input logic v, input logic [15:0] d);
        rst = r; start = st; in_valid = v; in_data = d;
        if (r) begin
            m_phase = 0; m_n = 0; m_we = 1'b0; m_addr = '0; m_data = '0;
        end else begin
            m_we = 1'b0;
            case (m_phase)
                0: if (st) m_phase = 1;
                1: if (v) begin
                       m_we   = 1'b1;
                       m_addr = {8'(m_n / OUT), 8'(m_n % OUT)};
                       m_data = relu(d);
                       m_n++;
                       if (m_n == BEATS) begin m_phase = 2; m_n = 0; end
                   end
                default: m_phase = 0;
            endcase
        end
        @(posedge clk); #1;
        compared++;
        if (mem_we !== m_we) begin
            mismatched++; $display("FAIL mem_we @%0t: got %b want %b", $time, mem_we, m_we);
        end
        compared++;
        if (mem_addr !== m_addr) begin
            mismatched++; $display("FAIL mem_addr @%0t: got %h want %h", $time, mem_addr, m_addr);
        end
        compared++;
        if (mem_data !== m_data) begin
            mismatched++; $display("FAIL mem_data @%0t: got %h want %h", $time, mem_data, m_data);
        end
        compared++;
        if (in_ready !== (m_phase == 1)) begin
            mismatched++; $display("FAIL in_ready @%0t: got %b want %b", $time, in_ready, m_phase == 1);
        end
        compared++;
        if (busy !== (m_phase != 0)) begin
            mismatched++; $display("FAIL busy @%0t: got %b want %b", $time, busy, m_phase != 0);
        end
        compared++;
        if (done !== (m_phase == 2)) begin
            mismatched++; $display("FAIL done @%0t: got %b want %b", $time, done, m_phase == 2);
        end
        if (done === 1'b1) done_seen++;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b1, 1'b1, 16'h1234);
        step(1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic test_idle_no_start();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 16'($urandom));
    endtask

    task automatic test_back_to_back();
        step(1'b0, 1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 2000 && m_phase == 1; i++) step(1'b0, 1'b0, 1'b1, 16'(m_n));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic test_valid_toggle();
        step(1'b0, 1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 2000 && m_phase == 1; i++) step(1'b0, 1'b0, 1'(i % 2), 16'(m_n));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    // Random gaps and random signed data; beat 5 is forced to -5. The start
    // cycle also carries a valid beat, which must not be accepted.
    task automatic test_random_relu();
        logic [15:0] d;
        step(1'b0, 1'b1, 1'b1, 16'hFFFB);
        for (int i = 0; i < 2000 && m_phase == 1; i++) begin
            d = (m_n == 5) ? 16'hFFFB : 16'($urandom);
            step(1'b0, 1'b0, 1'($urandom_range(0, 3) != 0), d);
        end
        step(1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic test_reset_mid_frame();
        step(1'b0, 1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 500 && m_n < 50; i++) step(1'b0, 1'b0, 1'b1, 16'($urandom));
        step(1'b1, 1'b0, 1'b1, 16'h5555);
        step(1'b0, 1'b0, 1'b1, 16'h6666);
        step(1'b0, 1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 2000 && m_phase == 1; i++) step(1'b0, 1'b0, 1'b1, 16'($urandom));
        step(1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic test_restart_ignored();
        done_seen = 0;
        step(1'b0, 1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 2000 && m_phase == 1; i++)
            step(1'b0, 1'(m_n == 70), 1'b1, 16'(m_n));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 16'h0);
        compared++;
        if (done_seen != 1) begin
            mismatched++; $display("FAIL done_count: got %0d want 1", done_seen);
        end
    endtask

    initial begin
        test_reset();
        test_idle_no_start();
        test_back_to_back();
        test_valid_toggle();
        test_random_relu();
        test_reset_mid_frame();
        test_restart_ignored();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
